// File: rtl/vga_frame_reader.sv
// Display-side reader of the camera frame buffer: 640x480@60 VGA timing,
// 2x-upscaled fetch of the 320x240 RGB565 buffer, 12-bit VGA output.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 320,
    parameter int FB_H     = 240
) (
    input  logic        pclk,
    input  logic        rst_n,
    output logic [16:0] addr,
    input  logic [15:0] din,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [8:0]  FB_ROWS    = 9'(FB_H);
    localparam logic [16:0] ROW_STRIDE = 17'(FB_W);

    // Control pipeline word: {act, hs, vs, fs}; idle value has syncs high.
    localparam logic [3:0]  CTL_IDLE   = 4'b0110;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [16:0] line_base_q, line_base_d;
    logic [16:0] addr_q, addr_d;
    logic [3:0]  ctl_p1_q, ctl_p1_d;
    logic [3:0]  ctl_p2_q, ctl_p2_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;

    logic        h_wrap, v_wrap;
    logic        act_p0, hs_p0, vs_p0, fs_p0;
    logic        din_unused;

    assign din_unused = ^{din[11], din[6:5], din[0]};

    // Stage 0: raster counters and position-derived control
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        act_p0  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_p0   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_p0   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        fs_p0   = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Stage 1: buffer address; a row base advances after each odd line so
    // line pairs share one buffer row, and addr freezes outside the picture.
    always_comb begin
        line_base_d = line_base_q;
        if (h_wrap && v_wrap) begin
            line_base_d = '0;
        end else if (h_wrap && v_cnt_q[0] && (v_cnt_q[9:1] < FB_ROWS)) begin
            line_base_d = line_base_q + ROW_STRIDE;
        end

        addr_d = addr_q;
        if (act_p0) begin
            addr_d = line_base_q + {8'd0, h_cnt_q[9:1]};
        end

        ctl_p1_d = {act_p0, hs_p0, vs_p0, fs_p0};
    end

    // Stage 2: din now holds the word for the address issued last cycle
    always_comb begin
        ctl_p2_d = ctl_p1_q;
    end

    // Stage 3: truncate RGB565 to 4:4:4 and register with aligned syncs
    always_comb begin
        rgb_d         = ctl_p2_q[3] ? {din[15:12], din[10:7], din[4:1]} : 12'd0;
        hsync_d       = ctl_p2_q[2];
        vsync_d       = ctl_p2_q[1];
        frame_start_d = ctl_p2_q[0];
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_base_q   <= '0;
            addr_q        <= '0;
            ctl_p1_q      <= CTL_IDLE;
            ctl_p2_q      <= CTL_IDLE;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_base_q   <= line_base_d;
            addr_q        <= addr_d;
            ctl_p1_q      <= ctl_p1_d;
            ctl_p2_q      <= ctl_p2_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign addr        = addr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full horizontal timing with a shortened frame
// height, BRAM model, raster-position reference model and measurements.
`timescale 1ns/1ps
module tb_vga_frame_reader;
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 8, VF = 2, VS = 2, VB = 3;
    localparam int FBW = HA / 2, FBH = VA / 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int MEMSZ = FBW * FBH;
    localparam int NTAB = 8;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [16:0] addr;
    logic [15:0] din;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;

    always #20 pclk = ~pclk;

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_W(FBW), .FB_H(FBH)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .addr(addr), .din(din),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    typedef struct {
        logic [15:0] pix;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } vec_t;
    vec_t tab [NTAB];

    logic [15:0] mem [MEMSZ];
    int edges;

    // BRAM with 1-cycle read latency; words fetched for horizontally blank
    // positions are replaced by all-ones so blanking must force black.
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            edges <= 0;
            din   <= 16'h0000;
        end else begin
            if (edges >= 1 && ((edges - 1) % HT) >= HA) din <= 16'hFFFF;
            else if (int'(addr) < MEMSZ) din <= mem[addr];
            else din <= 16'hDEAD;
            edges <= edges + 1;
        end
    end

    int checks = 0, errors = 0;
    int exp_addr = 0;
    bit ph_a = 0, tab_on = 0;
    int hs_fall, hs_low, vs_fall, vs_low, fs_n, fs_first, max_addr;
    logic prev_hs, prev_vs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d t=%0t",
                         name, act, act, exp, exp, edges, $time);
        end
    endtask

    task automatic reset_meas();
        hs_fall = -1; hs_low = 0; vs_fall = -1; vs_low = 0;
        fs_n = -1; fs_first = -1; max_addr = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        exp_addr = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    // Reference: output after edge n shows raster position n-3; addr after
    // edge n is the address of the latest active position at or before n-1.
    task automatic check_cycle();
        int n, p, h, v, q, hq, vq;
        logic [15:0] px;
        logic [3:0] er, eg, eb;
        logic ehs, evs, efs;
        n = edges;
        if (n >= 1) begin
            q = n - 1; hq = q % HT; vq = (q / HT) % VT;
            if (hq < HA && vq < VA) exp_addr = (vq / 2) * FBW + hq / 2;
        end
        er = 0; eg = 0; eb = 0; ehs = 1; evs = 1; efs = 0;
        h = 0; v = 0;
        if (n >= 3) begin
            p = n - 3; h = p % HT; v = (p / HT) % VT;
            if (h < HA && v < VA) begin
                px = mem[(v / 2) * FBW + h / 2];
                er = px[15:12]; eg = px[10:7]; eb = px[4:1];
            end
            ehs = !(h >= HA + HF && h < HA + HF + HS);
            evs = !(v >= VA + VF && v < VA + VF + VS);
            efs = (h == 0 && v == 0);
        end
        chk("addr", 32'(addr), 32'(exp_addr));
        chk("vga_r", 32'(vga_r), 32'(er));
        chk("vga_g", 32'(vga_g), 32'(eg));
        chk("vga_b", 32'(vga_b), 32'(eb));
        chk("hsync", 32'(hsync), 32'(ehs));
        chk("vsync", 32'(vsync), 32'(evs));
        chk("frame_start", 32'(frame_start), 32'(efs));
        if (tab_on && n >= 3 && v < 2 && h < 2 * NTAB)
            chk("tab_rgb", 32'({vga_r, vga_g, vga_b}),
                32'({tab[h / 2].r, tab[h / 2].g, tab[h / 2].b}));
        if (ph_a && n == HT + 1) chk("line1_start", 32'(addr), 32'd0);
        if (ph_a && n == 2 * HT + 1) chk("line2_start", 32'(addr), 32'(FBW));
        if (ph_a && n == (VA - 1) * HT + HA) chk("last_addr", 32'(addr), 32'(MEMSZ - 1));
    endtask

    task automatic measure();
        int n;
        n = edges;
        if (int'(addr) > max_addr) max_addr = int'(addr);
        if (prev_hs && !hsync) begin
            if (hs_fall >= 0) chk("hs_period", 32'(n - hs_fall), 32'(HT));
            if (fs_n >= 0 && n - fs_n < HT) chk("hs_align", 32'(n - fs_n), 32'(HA + HF));
            hs_fall = n; hs_low = 0;
        end
        if (!hsync) hs_low++;
        if (!prev_hs && hsync) chk("hs_width", 32'(hs_low), 32'(HS));
        if (prev_vs && !vsync) begin
            if (vs_fall >= 0) chk("vs_period", 32'(n - vs_fall), 32'(FRAME));
            vs_fall = n; vs_low = 0;
        end
        if (!vsync) vs_low++;
        if (!prev_vs && vsync) chk("vs_width", 32'(vs_low), 32'(VS * HT));
        if (frame_start) begin
            if (fs_n >= 0) chk("fs_period", 32'(n - fs_n), 32'(FRAME));
            if (fs_first < 0) fs_first = n;
            fs_n = n;
            if (tab_on) chk("fs_pixel", 32'({vga_r, vga_g, vga_b}), 32'h00F0F);
        end
        prev_hs = hsync; prev_vs = vsync;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge pclk);
            check_cycle();
            measure();
        end
    endtask

    initial begin
        tab[0] = '{16'hF81F, 4'hF, 4'h0, 4'hF};
        tab[1] = '{16'h07E0, 4'h0, 4'hF, 4'h0};
        tab[2] = '{16'hFFFF, 4'hF, 4'hF, 4'hF};
        tab[3] = '{16'h0000, 4'h0, 4'h0, 4'h0};
        tab[4] = '{16'h001E, 4'h0, 4'h0, 4'hF};
        tab[5] = '{16'h8000, 4'h8, 4'h0, 4'h0};
        tab[6] = '{16'h0842, 4'h0, 4'h0, 4'h1};
        tab[7] = '{16'h7BEF, 4'h7, 4'h7, 4'h7};
        for (int i = 0; i < MEMSZ; i++) mem[i] = 16'(i);
        for (int j = 0; j < NTAB; j++) mem[j] = tab[j].pix;

        rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        check_reset_values("por");
        reset_meas();
        rst_n = 1'b1;
        ph_a = 1; tab_on = 1;
        run(2 * FRAME + 5 * HT + 300);
        ph_a = 0; tab_on = 0;
        chk("addr_max", 32'(max_addr), 32'(MEMSZ - 1));
        chk("fs_first_a", 32'(fs_first), 32'd3);

        #3 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        for (int i = 0; i < MEMSZ; i++) mem[i] = 16'($urandom);
        reset_meas();
        run(5);
        rst_n = 1'b1;
        run(FRAME + 100);
        chk("fs_after_reset", 32'(fs_first), 32'd3);
        chk("addr_max_b", 32'(max_addr), 32'(MEMSZ - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
